// File: rtl/simulador_esteira_vinho_if.sv
// Actuator/sensor bundle between the line controller and the conveyor plant model.
// The controller side (master) drives the actuators and reads the sensors;
// the plant side (slave) does the opposite.
interface simulador_esteira_vinho_if;
   logic       MOTOR;
   logic       VALVULA_ENCHIMENTO;
   logic       ATUADOR_VEDACAO;
   logic       SENSOR_POS_ENCHIMENTO;
   logic       SENSOR_POS_CQ;
   logic       SENSOR_POS_LACRE;
   logic       SENSOR_GARRAFA_CHEIA;
   logic [7:0] POSICAO;
   logic [1:0] ESTADO_GARRAFA;
   logic [7:0] GARRAFAS_SAIDA;
   logic       ERRO_DERRAME;
   logic       ERRO_SEM_ROLHA;

   modport master (
      output MOTOR, VALVULA_ENCHIMENTO, ATUADOR_VEDACAO,
      input  SENSOR_POS_ENCHIMENTO, SENSOR_POS_CQ, SENSOR_POS_LACRE, SENSOR_GARRAFA_CHEIA,
      input  POSICAO, ESTADO_GARRAFA, GARRAFAS_SAIDA, ERRO_DERRAME, ERRO_SEM_ROLHA
   );

   modport slave (
      input  MOTOR, VALVULA_ENCHIMENTO, ATUADOR_VEDACAO,
      output SENSOR_POS_ENCHIMENTO, SENSOR_POS_CQ, SENSOR_POS_LACRE, SENSOR_GARRAFA_CHEIA,
      output POSICAO, ESTADO_GARRAFA, GARRAFAS_SAIDA, ERRO_DERRAME, ERRO_SEM_ROLHA
   );
endinterface

// File: rtl/simulador_esteira_vinho.sv
// Plant model of the wine bottling conveyor: turns the controller's actuator
// commands into position / fill sensors for a single bottle, counts bottles
// leaving the line and flags actuator misuse.
// Optional feature: define SIM_ERROS_EN to build the spill / missing-seal
// detectors; without it both error outputs are tied low.
module simulador_esteira_vinho #(
   parameter int PASSO_CICLOS     = 4,
   parameter int POS_ENCHIMENTO   = 2,
   parameter int POS_CQ           = 5,
   parameter int POS_LACRE        = 7,
   parameter int POS_FIM          = 9,
   parameter int TEMPO_ENCHIMENTO = 6
) (
   input logic                      CLK,
   input logic                      RESET,
   simulador_esteira_vinho_if.slave bus
);
   localparam int PW = (PASSO_CICLOS > 1) ? $clog2(PASSO_CICLOS) : 1;
   localparam int EW = $clog2(TEMPO_ENCHIMENTO + 1);

   localparam logic [7:0]    P_ENCH    = 8'(POS_ENCHIMENTO);
   localparam logic [7:0]    P_CQ      = 8'(POS_CQ);
   localparam logic [7:0]    P_LACRE   = 8'(POS_LACRE);
   localparam logic [7:0]    P_FIM     = 8'(POS_FIM);
   localparam logic [PW-1:0] PASSO_MAX = PW'(PASSO_CICLOS - 1);
   localparam logic [EW-1:0] ENCH_MAX  = EW'(TEMPO_ENCHIMENTO);

   typedef enum logic [1:0] {
      VAZIA    = 2'd0,
      ENCHENDO = 2'd1,
      CHEIA    = 2'd2,
      VEDADA   = 2'd3
   } estado_t;

   logic [7:0]    posicao;
   logic [PW-1:0] passo;
   logic [EW-1:0] enchimento;
   logic [7:0]    garrafas;
   estado_t       estado;
   estado_t       estado_prox;

   logic na_estacao;
   logic saida;
   logic enche;
   logic veda;

   // Qualifiers shared by the datapath and the bottle FSM
   always_comb begin
      na_estacao = (posicao == P_ENCH);
      saida      = (posicao == P_FIM);
      enche      = bus.VALVULA_ENCHIMENTO && na_estacao && !bus.MOTOR && (enchimento < ENCH_MAX);
      veda       = bus.ATUADOR_VEDACAO && na_estacao;
   end

   // Conveyor movement: prescaled motor steps, exit reload takes precedence over the motor
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         posicao <= 8'd0;
         passo   <= '0;
      end else if (saida) begin
         posicao <= 8'd0;
         passo   <= '0;
      end else if (bus.MOTOR) begin
         if (passo == PASSO_MAX) begin
            passo   <= '0;
            posicao <= posicao + 8'd1;
         end else begin
            passo <= passo + PW'(1);
         end
      end else begin
         passo <= '0;
      end
   end

   // Fill level: counts qualifying valve cycles, saturating at a full bottle
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         enchimento <= '0;
      end else if (saida) begin
         enchimento <= '0;
      end else if (enche) begin
         enchimento <= enchimento + EW'(1);
      end else begin
         enchimento <= enchimento;
      end
   end

   // Exit counter: one bottle per exit cycle, wraps naturally at 8 bits
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         garrafas <= 8'd0;
      end else if (saida) begin
         garrafas <= garrafas + 8'd1;
      end else begin
         garrafas <= garrafas;
      end
   end

   // Bottle FSM state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         estado <= VAZIA;
      end else begin
         estado <= estado_prox;
      end
   end

   // Bottle FSM next state; a fill cycle wins over a seal command in ENCHENDO
   always_comb begin
      estado_prox = estado;
      if (saida) begin
         estado_prox = VAZIA;
      end else begin
         case (estado)
            VAZIA: begin
               if (enche) begin
                  estado_prox = ((enchimento + EW'(1)) == ENCH_MAX) ? CHEIA : ENCHENDO;
               end else begin
                  estado_prox = VAZIA;
               end
            end
            ENCHENDO: begin
               if (enche && ((enchimento + EW'(1)) == ENCH_MAX)) begin
                  estado_prox = CHEIA;
               end else begin
                  estado_prox = ENCHENDO;
               end
            end
            CHEIA: begin
               if (veda) begin
                  estado_prox = VEDADA;
               end else begin
                  estado_prox = CHEIA;
               end
            end
            VEDADA:  estado_prox = VEDADA;
            default: estado_prox = VAZIA;
         endcase
      end
   end

   // Bottle FSM outputs and position-decoded sensors
   always_comb begin
      bus.ESTADO_GARRAFA        = estado;
      bus.POSICAO               = posicao;
      bus.GARRAFAS_SAIDA        = garrafas;
      bus.SENSOR_POS_ENCHIMENTO = na_estacao;
      bus.SENSOR_POS_CQ         = (posicao == P_CQ);
      bus.SENSOR_POS_LACRE      = (posicao == P_LACRE);
      bus.SENSOR_GARRAFA_CHEIA  = na_estacao && (enchimento == ENCH_MAX);
   end

`ifdef SIM_ERROS_EN
   logic erro_derrame;
   logic erro_sem_rolha;

   // Sticky misuse flags: valve open where it would spill, or a bottle leaving unsealed
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         erro_derrame   <= 1'b0;
         erro_sem_rolha <= 1'b0;
      end else begin
         if (bus.VALVULA_ENCHIMENTO && (!na_estacao || bus.MOTOR || (enchimento == ENCH_MAX))) begin
            erro_derrame <= 1'b1;
         end else begin
            erro_derrame <= erro_derrame;
         end
         if (saida && (estado != VEDADA)) begin
            erro_sem_rolha <= 1'b1;
         end else begin
            erro_sem_rolha <= erro_sem_rolha;
         end
      end
   end

   assign bus.ERRO_DERRAME   = erro_derrame;
   assign bus.ERRO_SEM_ROLHA = erro_sem_rolha;
`else
   assign bus.ERRO_DERRAME   = 1'b0;
   assign bus.ERRO_SEM_ROLHA = 1'b0;
`endif

endmodule

// File: tb/tb_simulador_esteira_vinho.sv
// Scoreboard bench for the conveyor plant model: directed scenarios from the
// line's acceptance sequence followed by biased random actuator traffic.
module tb_simulador_esteira_vinho;
   localparam int PASSO  = 4;
   localparam int P_ENCH = 2;
   localparam int P_CQ   = 5;
   localparam int P_LAC  = 7;
   localparam int P_FIM  = 9;
   localparam int TEMPO  = 6;

   logic CLK = 1'b0;
   logic RESET;
   int   checks   = 0;
   int   failures = 0;

   simulador_esteira_vinho_if bus ();

   simulador_esteira_vinho dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Reference model: one bottle described with plain integers
   int m_pos, m_run, m_fill, m_st, m_count;
   bit m_derr, m_rolha;
   logic [23:0] q[$];

   function automatic void model_reset();
      m_pos = 0; m_run = 0; m_fill = 0; m_st = 0; m_count = 0;
      m_derr = 1'b0; m_rolha = 1'b0;
   endfunction

   function automatic void model_step(bit m, bit v, bit a);
      int pos0  = m_pos;
      int fill0 = m_fill;
      if (v && (pos0 != P_ENCH || m || fill0 == TEMPO)) m_derr = 1'b1;
      if (pos0 == P_FIM) begin
         m_count = (m_count + 1) % 256;
         if (m_st != 3) m_rolha = 1'b1;
         m_pos = 0; m_run = 0; m_fill = 0; m_st = 0;
      end else begin
         if (m) begin
            m_run = m_run + 1;
            if (m_run == PASSO) begin
               m_run = 0;
               m_pos = m_pos + 1;
            end
         end else begin
            m_run = 0;
         end
         if (v && pos0 == P_ENCH && !m && fill0 < TEMPO) begin
            m_fill = fill0 + 1;
            m_st   = (m_fill == TEMPO) ? 2 : 1;
         end else if (a && m_st == 2 && pos0 == P_ENCH) begin
            m_st = 3;
         end
      end
   endfunction

   function automatic logic [23:0] model_vec();
      bit d, r;
`ifdef SIM_ERROS_EN
      d = m_derr; r = m_rolha;
`else
      d = 1'b0; r = 1'b0;
`endif
      return {m_pos == P_ENCH, m_pos == P_CQ, m_pos == P_LAC,
              (m_pos == P_ENCH) && (m_fill == TEMPO),
              8'(m_pos), 2'(m_st), 8'(m_count), d, r};
   endfunction

   function automatic logic [23:0] dut_vec();
      return {bus.SENSOR_POS_ENCHIMENTO, bus.SENSOR_POS_CQ, bus.SENSOR_POS_LACRE,
              bus.SENSOR_GARRAFA_CHEIA, bus.POSICAO, bus.ESTADO_GARRAFA,
              bus.GARRAFAS_SAIDA, bus.ERRO_DERRAME, bus.ERRO_SEM_ROLHA};
   endfunction

   function automatic void compare(string name, logic [23:0] act, logic [23:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s t=%0t actual sens=%b pos=%0d st=%0d cnt=%0d err=%b required sens=%b pos=%0d st=%0d cnt=%0d err=%b",
                  name, $time, act[23:20], act[19:12], act[11:10], act[9:2], act[1:0],
                  req[23:20], req[19:12], req[11:10], req[9:2], req[1:0]);
      end
   endfunction

   // Monitor: after every active edge compare the DUT against the oldest expectation
   always @(posedge CLK) begin
      #1;
      if (q.size() > 0) begin
         compare("cycle", dut_vec(), q.pop_front());
      end
   end

   task automatic step(bit m, bit v, bit a);
      @(negedge CLK);
      bus.MOTOR = m;
      bus.VALVULA_ENCHIMENTO = v;
      bus.ATUADOR_VEDACAO = a;
      model_step(m, v, a);
      q.push_back(model_vec());
      @(posedge CLK);
   endtask

   task automatic steps(int n, bit m, bit v, bit a);
      for (int i = 0; i < n; i++) step(m, v, a);
   endtask

   // Reset asserted mid-cycle; outputs must clear before the next edge
   task automatic reset_async(string name);
      @(negedge CLK);
      bus.MOTOR = 1'b0;
      bus.VALVULA_ENCHIMENTO = 1'b0;
      bus.ATUADOR_VEDACAO = 1'b0;
      #2;
      RESET = 1'b1;
      #1;
      model_reset();
      compare(name, dut_vec(), model_vec());
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit m, v, a;
      RESET = 1'b1;
      bus.MOTOR = 1'b0;
      bus.VALVULA_ENCHIMENTO = 1'b0;
      bus.ATUADOR_VEDACAO = 1'b0;
      model_reset();
      #1;
      compare("reset_initial", dut_vec(), model_vec());
      @(negedge CLK);
      RESET = 1'b0;

      // Move to the filling station, fill, overfill, seal, travel, exit sealed
      steps(8, 1'b1, 1'b0, 1'b0);
      steps(6, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      steps(28, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Unfilled bottle run to the exit
      reset_async("reset_scn2");
      steps(36, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      // Interrupted step restarts from zero
      reset_async("reset_scn3");
      steps(3, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      steps(3, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);

      // Seal attempted while still filling is ignored, then reset mid-fill
      reset_async("reset_scn4");
      steps(8, 1'b1, 1'b0, 1'b0);
      steps(2, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      reset_async("reset_mid_fill");

      // Biased random traffic with occasional asynchronous resets
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            reset_async("reset_random");
         end
         if (m_pos == P_ENCH) begin
            m = ($urandom_range(0, 7) == 0);
            v = (m_fill < TEMPO) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            a = ($urandom_range(0, 3) == 0);
         end else begin
            m = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 63) == 0);
            a = ($urandom_range(0, 7) == 0);
         end
         step(m, v, a);
      end

      @(negedge CLK);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain actual pending=%0d required pending=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
